// File: rtl/mux_16x1_t_reqs_if.sv
// Bundles the lane inputs, select, enable and the combinational/registered outputs of the 16:1 mux.
// Optional one-hot select output is present when MUX_16X1_T_ONEHOT_EN is defined.
interface mux_16x1_t_reqs_if #(
    parameter int unsigned WIDTH = 1
);
    localparam int unsigned LANES = 16;

    logic [LANES*WIDTH-1:0] in;
    logic [3:0]             sel;
    logic                   en;
    logic [WIDTH-1:0]       o;
    logic [WIDTH-1:0]       o_q;
    logic [3:0]             sel_q;
    logic                   valid_q;
`ifdef MUX_16X1_T_ONEHOT_EN
    logic [LANES-1:0]       sel_oh;

    modport master (
        output in, sel, en,
        input  o, o_q, sel_q, valid_q, sel_oh
    );

    modport slave (
        input  in, sel, en,
        output o, o_q, sel_q, valid_q, sel_oh
    );
`else
    modport master (
        output in, sel, en,
        input  o, o_q, sel_q, valid_q
    );

    modport slave (
        input  in, sel, en,
        output o, o_q, sel_q, valid_q
    );
`endif

endinterface

// File: rtl/mux_16x1_t_reqs.sv
// 16:1 mux built as a 4-level 2:1 tree with an enabled output register.
// Define MUX_16X1_T_ONEHOT_EN to add the combinational one-hot select decode sel_oh.
module mux_16x1_t_reqs #(
    parameter int unsigned WIDTH = 1
) (
    input logic              clk,
    input logic              rst,
    mux_16x1_t_reqs_if.slave bus
);

    logic [WIDTH-1:0] lvl0 [8];
    logic [WIDTH-1:0] lvl1 [4];
    logic [WIDTH-1:0] lvl2 [2];
    logic [WIDTH-1:0] o_c;

    // Level n of the tree resolves sel[n]; lane order is preserved at every level.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl0[i] = bus.sel[0] ? bus.in[(2*i+1)*WIDTH +: WIDTH]
                                 : bus.in[(2*i)*WIDTH +: WIDTH];
        end
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = bus.sel[1] ? lvl0[2*i+1] : lvl0[2*i];
        end
        for (int i = 0; i < 2; i++) begin
            lvl2[i] = bus.sel[2] ? lvl1[2*i+1] : lvl1[2*i];
        end
        o_c = bus.sel[3] ? lvl2[1] : lvl2[0];
    end

    assign bus.o = o_c;

    // Reset wins over enable; a disabled edge holds the captured sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_q     <= '0;
            bus.sel_q   <= 4'd0;
            bus.valid_q <= 1'b0;
        end else if (bus.en) begin
            bus.o_q     <= o_c;
            bus.sel_q   <= bus.sel;
            bus.valid_q <= 1'b1;
        end
    end

`ifdef MUX_16X1_T_ONEHOT_EN
    assign bus.sel_oh = 16'(16'd1 << bus.sel);
`endif

endmodule

// File: tb/tb_mux_16x1_t_reqs.sv
// Bench for mux_16x1_t_reqs: directed requirement checks plus randomized traffic on WIDTH=1 and WIDTH=4 instances.
module tb_mux_16x1_t_reqs;

    logic clk;
    logic rst;
    logic en;
    logic [3:0]  sel;
    logic [15:0] in1;
    logic [63:0] in4;

    int total = 0;
    int bad   = 0;

    // Expected register contents per instance
    logic [0:0] e1_oq;
    logic [3:0] e4_oq;
    logic [3:0] e_selq;
    logic       e_valid;

    mux_16x1_t_reqs_if #(.WIDTH(1)) b1 ();
    mux_16x1_t_reqs_if #(.WIDTH(4)) b4 ();

    assign b1.in  = in1;
    assign b1.sel = sel;
    assign b1.en  = en;
    assign b4.in  = in4;
    assign b4.sel = sel;
    assign b4.en  = en;

    mux_16x1_t_reqs #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mux_16x1_t_reqs #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lane s of a packed vector, by plain shift-and-mask arithmetic.
    function automatic logic [3:0] lane(input logic [63:0] v, input int s, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return 4'((v >> (s * w)) & m);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_o(input string tag);
        chk({tag, "_o1"}, 64'(b1.o), 64'(lane(64'(in1), int'(sel), 1)));
        chk({tag, "_o4"}, 64'(b4.o), 64'(lane(in4, int'(sel), 4)));
    endtask

    // Advance one edge, updating the model from pre-edge inputs, then check everything.
    task automatic step(input string tag);
        if (rst) begin
            e1_oq = '0; e4_oq = '0; e_selq = '0; e_valid = 1'b0;
        end else if (en) begin
            e1_oq   = 1'(lane(64'(in1), int'(sel), 1));
            e4_oq   = lane(in4, int'(sel), 4);
            e_selq  = sel;
            e_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_oq1"},  64'(b1.o_q),     64'(e1_oq));
        chk({tag, "_oq4"},  64'(b4.o_q),     64'(e4_oq));
        chk({tag, "_selq1"}, 64'(b1.sel_q),  64'(e_selq));
        chk({tag, "_selq4"}, 64'(b4.sel_q),  64'(e_selq));
        chk({tag, "_vld1"}, 64'(b1.valid_q), 64'(e_valid));
        chk({tag, "_vld4"}, 64'(b4.valid_q), 64'(e_valid));
        check_o(tag);
    endtask

    logic [15:0] sweep_exp;

    initial begin
        rst = 1'b1; en = 1'b1; sel = 4'd5; in1 = 16'hFFFF; in4 = '1;
        e1_oq = '0; e4_oq = '0; e_selq = '0; e_valid = 1'b0;
        #1;

        // Reset held two cycles with en=1: registers cleared, o unaffected
        for (int c = 0; c < 2; c++) begin
            step("reset");
            chk("reset_o_high", 64'(b1.o), 64'd1);
        end

        // Registered path capture then hold
        rst = 1'b0; en = 1'b1; sel = 4'd3; in1 = 16'hA898;
        step("cap");
        chk("cap_oq_const",   64'(b1.o_q),     64'd1);
        chk("cap_selq_const", 64'(b1.sel_q),   64'd3);
        chk("cap_vld_const",  64'(b1.valid_q), 64'd1);
        en = 1'b0; sel = 4'd2;
        #1;
        chk("hold_o_now", 64'(b1.o), 64'd0);
        step("hold");
        chk("hold_oq_const",   64'(b1.o_q),   64'd1);
        chk("hold_selq_const", 64'(b1.sel_q), 64'd3);

        // Sel sweep on 16'hA898 with a fixed expected sequence
        sweep_exp = 16'b1010_1000_1001_1000;
        in1 = 16'hA898;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            #10;
            chk($sformatf("sweep_sel%0d", s), 64'(b1.o), 64'(sweep_exp[s]));
        end

        // Walking one across all lanes and selects
        for (int k = 0; k < 16; k++) begin
            in1 = 16'(16'd1 << k);
            for (int s = 0; s < 16; s++) begin
                sel = 4'(s);
                #1;
                chk($sformatf("walk_k%0d_s%0d", k, s), 64'(b1.o), (s == k) ? 64'd1 : 64'd0);
            end
        end

        // WIDTH=4 lanes loaded with their own index
        for (int k = 0; k < 16; k++) in4[k*4 +: 4] = 4'(k);
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            #1;
            chk($sformatf("w4_sel%0d", s), 64'(b4.o), 64'(s));
        end

`ifdef MUX_16X1_T_ONEHOT_EN
        sel = 4'd9; #1;
        chk("oh_sel9", 64'(b1.sel_oh), 64'h0200);
        sel = 4'd0; #1;
        chk("oh_sel0", 64'(b4.sel_oh), 64'h0001);
`endif

        // Randomized traffic with mid-cycle input changes
        for (int n = 0; n < 300; n++) begin
            in1 = 16'($urandom);
            in4 = {$urandom, $urandom};
            sel = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            #2;
            check_o("rnd_pre");
            in1 = 16'($urandom);
            sel = 4'($urandom_range(0, 15));
            #1;
            check_o("rnd_mid");
`ifdef MUX_16X1_T_ONEHOT_EN
            chk("rnd_oh", 64'(b1.sel_oh), 64'(16'd1 << sel));
`endif
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
